// File: rtl/quidditch_pkg.sv
// quidditch_pkg: shared geometry constants and the arbiter FSM state type.
`default_nettype none

package quidditch_pkg;

  localparam int COORD_W_DEF      = 10;
  localparam int PLAYER_RADIUS    = 25;
  // Two radii plus a 2 px guard band.
  localparam int CONTACT_DIST_DEF = 2 * PLAYER_RADIUS + 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } arb_state_e;

endpackage

`default_nettype wire

// File: rtl/rr_arbiter.sv
// rr_arbiter: one-hot round-robin pick, searching from the index after ptr_i.
`default_nettype none

module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] gnt_o
);

  logic             found;
  logic [IDX_W-1:0] idx;

  always_comb begin
    gnt_o = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = IDX_W'((int'(ptr_i) + k) % NUM_REQ);
      if (!found && req_i[idx]) begin
        gnt_o[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/dist_check_arbiter.sv
// dist_check_arbiter: round-robin shared 3-stage squared-distance contact checker.
// Optional per-requester hit counters when DIST_CHECK_ARB_STATS_EN is defined.
`default_nettype none

module dist_check_arbiter
  import quidditch_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int COORD_W      = COORD_W_DEF,
  parameter int CONTACT_DIST = CONTACT_DIST_DEF
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       en,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*COORD_W-1:0] req_ax,
  input  logic [NUM_REQ*COORD_W-1:0] req_ay,
  input  logic [NUM_REQ*COORD_W-1:0] req_bx,
  input  logic [NUM_REQ*COORD_W-1:0] req_by,
  output logic [NUM_REQ-1:0]         gnt,
  output logic                       res_valid,
  output logic [2:0]                 res_tag,
  output logic                       res_hit,
  output logic                       res_a_below,
  output logic                       idle
`ifdef DIST_CHECK_ARB_STATS_EN
  ,
  output logic [NUM_REQ*16-1:0]      hit_cnt
`endif
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int SQ_W  = 2 * COORD_W;
  localparam int SUM_W = 2 * COORD_W + 1;
  localparam logic [SUM_W-1:0] CD_SQ = SUM_W'(CONTACT_DIST * CONTACT_DIST);

  arb_state_e       state_q, state_d;
  logic [IDX_W-1:0] ptr_q;
  logic [NUM_REQ-1:0] arb_req;
  logic [IDX_W-1:0] gidx;
  logic             pipe_empty;

  logic [COORD_W-1:0] sel_ax, sel_ay, sel_bx, sel_by;
  logic signed [COORD_W:0] dx_w, dy_w;

  logic                    s1_v_q, s1_below_q;
  logic [2:0]              s1_tag_q;
  logic signed [COORD_W:0] s1_dx_q, s1_dy_q;
  logic [COORD_W:0]        adx_w, ady_w;
  logic [SQ_W-1:0]         sqx_w, sqy_w;

  logic             s2_v_q, s2_below_q;
  logic [2:0]       s2_tag_q;
  logic [SQ_W-1:0]  s2_sqx_q, s2_sqy_q;
  logic [SUM_W-1:0] sum_w;

  logic       res_valid_q, res_hit_q, res_a_below_q;
  logic [2:0] res_tag_q;

  // Grants only while running with enable still sampled high, so no grant
  // ever issues in the cycle en falls.
  assign arb_req = (state_q == RUN && en) ? req : '0;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr (
    .req_i (arb_req),
    .ptr_i (ptr_q),
    .gnt_o (gnt)
  );

  always_comb begin
    gidx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) gidx = IDX_W'(i);
    end
  end

  assign pipe_empty = !(s1_v_q || s2_v_q || res_valid_q);
  assign idle       = (state_q == IDLE) && pipe_empty;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (en) state_d = RUN;
      RUN:     if (!en) state_d = DRAIN;
      DRAIN: begin
        if (en)              state_d = RUN;
        else if (pipe_empty) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= IDX_W'(NUM_REQ - 1);
    end else begin
      state_q <= state_d;
      if (|gnt) ptr_q <= gidx;
    end
  end

  assign sel_ax = req_ax[gidx*COORD_W +: COORD_W];
  assign sel_ay = req_ay[gidx*COORD_W +: COORD_W];
  assign sel_bx = req_bx[gidx*COORD_W +: COORD_W];
  assign sel_by = req_by[gidx*COORD_W +: COORD_W];
  assign dx_w   = $signed({1'b0, sel_ax}) - $signed({1'b0, sel_bx});
  assign dy_w   = $signed({1'b0, sel_ay}) - $signed({1'b0, sel_by});

  // Squaring the magnitude keeps the multiply unsigned and full-width.
  assign adx_w = s1_dx_q[COORD_W] ? $unsigned(-s1_dx_q) : $unsigned(s1_dx_q);
  assign ady_w = s1_dy_q[COORD_W] ? $unsigned(-s1_dy_q) : $unsigned(s1_dy_q);
  assign sqx_w = SQ_W'(adx_w) * SQ_W'(adx_w);
  assign sqy_w = SQ_W'(ady_w) * SQ_W'(ady_w);
  assign sum_w = SUM_W'(s2_sqx_q) + SUM_W'(s2_sqy_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v_q        <= 1'b0;
      s1_below_q    <= 1'b0;
      s1_tag_q      <= '0;
      s1_dx_q       <= '0;
      s1_dy_q       <= '0;
      s2_v_q        <= 1'b0;
      s2_below_q    <= 1'b0;
      s2_tag_q      <= '0;
      s2_sqx_q      <= '0;
      s2_sqy_q      <= '0;
      res_valid_q   <= 1'b0;
      res_tag_q     <= '0;
      res_hit_q     <= 1'b0;
      res_a_below_q <= 1'b0;
    end else begin
      s1_v_q      <= |gnt;
      s2_v_q      <= s1_v_q;
      res_valid_q <= s2_v_q;
      if (|gnt) begin
        s1_tag_q   <= 3'(gidx);
        s1_dx_q    <= dx_w;
        s1_dy_q    <= dy_w;
        s1_below_q <= sel_ay > sel_by;
      end
      if (s1_v_q) begin
        s2_tag_q   <= s1_tag_q;
        s2_sqx_q   <= sqx_w;
        s2_sqy_q   <= sqy_w;
        s2_below_q <= s1_below_q;
      end
      // Result fields hold their last value between strobes.
      if (s2_v_q) begin
        res_tag_q     <= s2_tag_q;
        res_hit_q     <= sum_w < CD_SQ;
        res_a_below_q <= s2_below_q;
      end
    end
  end

  assign res_valid   = res_valid_q;
  assign res_tag     = res_tag_q;
  assign res_hit     = res_hit_q;
  assign res_a_below = res_a_below_q;

`ifdef DIST_CHECK_ARB_STATS_EN
  logic [NUM_REQ-1:0][15:0] hit_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_cnt_q <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (res_valid_q && res_hit_q && res_tag_q == 3'(i) && hit_cnt_q[i] != 16'hFFFF)
          hit_cnt_q[i] <= hit_cnt_q[i] + 16'd1;
      end
    end
  end

  assign hit_cnt = hit_cnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_dist_check_arbiter.sv
// tb_dist_check_arbiter: directed + randomized bench with a queue-based reference model.
`default_nettype none

module tb_dist_check_arbiter;

  localparam int NUM_REQ = 4;
  localparam int CW      = 10;
  localparam int CD      = 52;
  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_DRAIN = 2;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic                  en = 1'b0;
  logic [NUM_REQ-1:0]    req = '0;
  logic [NUM_REQ*CW-1:0] req_ax = '0, req_ay = '0, req_bx = '0, req_by = '0;
  logic [NUM_REQ-1:0]    gnt;
  logic                  res_valid, res_hit, res_a_below, idle;
  logic [2:0]            res_tag;
`ifdef DIST_CHECK_ARB_STATS_EN
  logic [NUM_REQ*16-1:0] hit_cnt;
`endif

  dist_check_arbiter #(
    .NUM_REQ      (NUM_REQ),
    .COORD_W      (CW),
    .CONTACT_DIST (CD)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .req         (req),
    .req_ax      (req_ax),
    .req_ay      (req_ay),
    .req_bx      (req_bx),
    .req_by      (req_by),
    .gnt         (gnt),
    .res_valid   (res_valid),
    .res_tag     (res_tag),
    .res_hit     (res_hit),
    .res_a_below (res_a_below),
    .idle        (idle)
`ifdef DIST_CHECK_ARB_STATS_EN
    ,
    .hit_cnt     (hit_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: expected results queued with the cycle they must appear in.
  typedef struct {
    int         due;
    logic [2:0] tag;
    logic       hit;
    logic       below;
  } res_t;

  res_t q[$];
  int   cyc    = 0;
  int   m_mode = M_IDLE;
  int   m_last = NUM_REQ - 1;
  logic [2:0] h_tag = '0;
  logic h_hit = 1'b0, h_below = 1'b0;

  logic [NUM_REQ-1:0] cap_gnt = '0;
  logic cap_valid = 1'b0, cap_hit = 1'b0, cap_below = 1'b0, cap_idle = 1'b0;
  logic [2:0] cap_tag = '0;

  function automatic int coord(logic [NUM_REQ*CW-1:0] bus, int i);
    logic [CW-1:0] v;
    v = bus[i*CW +: CW];
    return int'(v);
  endfunction

  always @(negedge clk) begin
    logic [NUM_REQ-1:0] eg;
    int   gi, dx, dy;
    logic ev, eidle, empty_now;
    res_t r;
    if (!rst_n) begin
      m_mode = M_IDLE;
      m_last = NUM_REQ - 1;
      q.delete();
      h_tag = '0; h_hit = 1'b0; h_below = 1'b0;
      check("rst_gnt", 32'(gnt), 0);
      check("rst_valid", 32'(res_valid), 0);
      check("rst_tag", 32'(res_tag), 0);
      check("rst_hit", 32'(res_hit), 0);
      check("rst_below", 32'(res_a_below), 0);
      check("rst_idle", 32'(idle), 1);
    end else begin
      eg = '0;
      gi = 0;
      if (m_mode == M_RUN && en) begin
        for (int k = 1; k <= NUM_REQ; k++) begin
          int j;
          j = (m_last + k) % NUM_REQ;
          if (eg == '0 && req[j]) begin
            eg[j] = 1'b1;
            gi    = j;
          end
        end
      end
      ev = (q.size() > 0) && (q[0].due == cyc);
      if (ev) begin
        h_tag = q[0].tag; h_hit = q[0].hit; h_below = q[0].below;
      end
      empty_now = (q.size() == 0);
      eidle     = (m_mode == M_IDLE) && empty_now;
      check("gnt", 32'(gnt), 32'(eg));
      check("res_valid", 32'(res_valid), 32'(ev));
      check("res_tag", 32'(res_tag), 32'(h_tag));
      check("res_hit", 32'(res_hit), 32'(h_hit));
      check("res_a_below", 32'(res_a_below), 32'(h_below));
      check("idle", 32'(idle), 32'(eidle));
      if (ev) void'(q.pop_front());
      if (eg != '0) begin
        dx = coord(req_ax, gi) - coord(req_bx, gi);
        dy = coord(req_ay, gi) - coord(req_by, gi);
        r.due   = cyc + 3;
        r.tag   = 3'(gi);
        r.hit   = (dx * dx + dy * dy) < CD * CD;
        r.below = coord(req_ay, gi) > coord(req_by, gi);
        q.push_back(r);
        m_last = gi;
      end
      case (m_mode)
        M_IDLE:  if (en) m_mode = M_RUN;
        M_RUN:   if (!en) m_mode = M_DRAIN;
        default: begin
          if (en)             m_mode = M_RUN;
          else if (empty_now) m_mode = M_IDLE;
        end
      endcase
    end
    cap_gnt = gnt; cap_valid = res_valid; cap_tag = res_tag;
    cap_hit = res_hit; cap_below = res_a_below; cap_idle = idle;
    cyc++;
  end

  // Advance one cycle; a requester drops req once it has seen its grant.
  task automatic tick();
    @(posedge clk);
    #1;
    req = req & ~cap_gnt;
  endtask

  task automatic set_slot(int i, int ax, int ay, int bx, int by);
    req_ax[i*CW +: CW] = CW'(ax);
    req_ay[i*CW +: CW] = CW'(ay);
    req_bx[i*CW +: CW] = CW'(bx);
    req_by[i*CW +: CW] = CW'(by);
  endtask

  task automatic single(string nm, int ax, int ay, int bx, int by, logic eh, logic eb);
    set_slot(0, ax, ay, bx, by);
    req[0] = 1'b1;
    tick();
    check({nm, "_gnt"}, 32'(cap_gnt), 1);
    tick();
    tick();
    check({nm, "_early"}, 32'(cap_valid), 0);
    tick();
    check({nm, "_valid"}, 32'(cap_valid), 1);
    check({nm, "_tag"}, 32'(cap_tag), 0);
    check({nm, "_hit"}, 32'(cap_hit), 32'(eh));
    check({nm, "_below"}, 32'(cap_below), 32'(eb));
  endtask

  function automatic int near(int base);
    int v;
    v = base + int'($urandom_range(0, 120)) - 60;
    if (v < 0) v = 0;
    if (v > 1023) v = 1023;
    return v;
  endfunction

  initial begin
    logic [NUM_REQ-1:0] seq [$];
    logic [NUM_REQ-1:0] exp_seq [5];
    int   nv, ng, ax, ay;
    logic seen_early;

    exp_seq[0] = 4'b0001; exp_seq[1] = 4'b0010; exp_seq[2] = 4'b0100;
    exp_seq[3] = 4'b1000; exp_seq[4] = 4'b0001;

    tick();
    tick();
    check("init_idle", 32'(cap_idle), 1);
    rst_n = 1'b1;
    en    = 1'b1;
    tick();

    // Hand-computed: 2500 < 2704 hits; 2704 is not strictly below and misses.
    single("hit", 100, 200, 100, 250, 1'b1, 1'b0);
    single("miss", 100, 300, 100, 248, 1'b0, 1'b1);
    single("ext1", 0, 0, 1023, 1023, 1'b0, 1'b0);
    single("ext2", 1023, 1023, 0, 0, 1'b0, 1'b1);

    // Reset with three results in flight.
    for (int i = 0; i < NUM_REQ; i++) set_slot(i, 10 * i, 20, 10 * i + 5, 30);
    for (int i = 0; i < 3; i++) begin
      req = '1;
      tick();
    end
    rst_n = 1'b0;
    #1;
    check("mid_rst_gnt", 32'(gnt), 0);
    check("mid_rst_valid", 32'(res_valid), 0);
    check("mid_rst_tag", 32'(res_tag), 0);
    check("mid_rst_hit", 32'(res_hit), 0);
    check("mid_rst_below", 32'(res_a_below), 0);
    check("mid_rst_idle", 32'(idle), 1);
    tick();
    rst_n = 1'b1;
    req   = '1;
    seen_early = 1'b0;
    for (int k = 0; k < 12 && seq.size() < 5; k++) begin
      tick();
      if (cap_gnt != '0) seq.push_back(cap_gnt);
      else if (cap_valid) seen_early = 1'b1;
      req = '1;
    end
    check("post_rst_no_valid", 32'(seen_early), 0);
    check("rr_count", seq.size(), 5);
    for (int i = 0; i < 5 && i < seq.size(); i++)
      check($sformatf("rr_order%0d", i), 32'(seq[i]), 32'(exp_seq[i]));

    // Drain with three grants in flight.
    en = 1'b0;
    nv = 0;
    ng = 0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (cap_valid) nv++;
      if (cap_gnt != '0) ng++;
    end
    check("drain_valids", nv, 3);
    check("drain_gnts", ng, 0);
    check("drain_idle", 32'(cap_idle), 1);

    // Randomized traffic with occasional enable toggles and resets.
    req = '0;
    en  = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      tick();
      if ($urandom_range(0, 499) == 0) begin
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
      end
      if ($urandom_range(0, 39) == 0) en = ~en;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!req[i] && $urandom_range(0, 2) == 0) begin
          ax = int'($urandom_range(0, 1023));
          ay = int'($urandom_range(0, 1023));
          if ($urandom_range(0, 7) == 0)
            set_slot(i, ax, ay, int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)));
          else
            set_slot(i, ax, ay, near(ax), near(ay));
          req[i] = 1'b1;
        end
      end
    end

    en = 1'b0;
    for (int k = 0; k < 10; k++) tick();
    check("final_idle", 32'(cap_idle), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
